// File: rtl/float_adder_e4m3.sv
// Iterative E4M3 adder: one alignment or normalisation shift per cycle, truncating.
// Accepts one operand pair per IDLE visit and pulses is_output_valid for one cycle in DONE.
module float_adder_e4m3 #(
    parameter int         BIAS       = 7,
    parameter logic [6:0] MAX_FINITE = 7'h7E
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       is_output_valid,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t             r_state;
    logic               r_sign;
    logic               r_sub;
    logic [3:0]         r_ml;
    logic [3:0]         r_ms;
    logic [1:0]         r_d;
    logic [4:0]         r_sum;
    logic signed [5:0]  r_exp;      // unbiased exponent of the result
    logic [7:0]         r_y;
    logic               r_vld;

    logic               w_a_nan, w_b_nan, w_a_zero, w_b_zero, w_a_big;
    logic [7:0]         w_l;
    logic [6:0]         w_s;
    logic [3:0]         w_d;
    logic [4:0]         w_sum;
    logic signed [5:0]  w_exp_b;

    assign w_a_nan  = (a[6:0] == 7'h7F);
    assign w_b_nan  = (b[6:0] == 7'h7F);
    assign w_a_zero = (a[6:3] == 4'd0);
    assign w_b_zero = (b[6:3] == 4'd0);
    assign w_a_big  = (a[6:0] >= b[6:0]);
    assign w_l      = w_a_big ? a : b;
    assign w_s      = w_a_big ? b[6:0] : a[6:0];
    assign w_d      = w_l[6:3] - w_s[6:3];
    assign w_sum    = r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});
    assign w_exp_b  = r_exp + 6'(BIAS);

    assign in_ready        = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign y               = r_y;
    assign is_output_valid = r_vld;

    // Saturates anything above the largest finite magnitude, including the NaN code.
    function automatic logic [7:0] pack(input logic s, input logic signed [5:0] eb, input logic [2:0] m);
        if (eb > 6'sd15 || (eb == 6'sd15 && m == 3'b111))
            return {s, MAX_FINITE};
        return {s, eb[3:0], m};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_sub   <= 1'b0;
            r_ml    <= '0;
            r_ms    <= '0;
            r_d     <= '0;
            r_sum   <= '0;
            r_exp   <= '0;
            r_y     <= 8'h00;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vld <= 1'b0;
                    if (in_valid) begin
                        if (w_a_nan || w_b_nan) begin
                            r_y <= 8'h7F; r_vld <= 1'b1; r_state <= S_DONE;
                        end else if (w_a_zero && w_b_zero) begin
                            r_y <= 8'h00; r_vld <= 1'b1; r_state <= S_DONE;
                        end else if (w_a_zero) begin
                            r_y <= b; r_vld <= 1'b1; r_state <= S_DONE;
                        end else if (w_b_zero) begin
                            r_y <= a; r_vld <= 1'b1; r_state <= S_DONE;
                        end else begin
                            r_sign <= w_l[7];
                            r_sub  <= a[7] ^ b[7];
                            r_ml   <= {1'b1, w_l[2:0]};
                            r_exp  <= 6'({2'b00, w_l[6:3]}) - 6'(BIAS);
                            r_d    <= w_d[1:0];
                            if (w_d >= 4'd4) begin
                                r_ms    <= 4'd0;
                                r_state <= S_ADD;
                            end else begin
                                r_ms    <= {1'b1, w_s[2:0]};
                                r_state <= (w_d == 4'd0) ? S_ADD : S_ALIGN;
                            end
                        end
                    end
                end
                S_ALIGN: begin
                    r_ms <= r_ms >> 1;
                    r_d  <= r_d - 2'd1;
                    if (r_d == 2'd1)
                        r_state <= S_ADD;
                end
                S_ADD: begin
                    r_sum <= w_sum;
                    if (w_sum == 5'd0) begin
                        r_y <= 8'h00; r_vld <= 1'b1; r_state <= S_DONE;
                    end else begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_sum[4]) begin
                        r_exp   <= r_exp + 6'sd1;
                        r_y     <= pack(r_sign, w_exp_b + 6'sd1, r_sum[3:1]);
                        r_vld   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_sum[3]) begin
                        r_y     <= pack(r_sign, w_exp_b, r_sum[2:0]);
                        r_vld   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_exp_b == 6'sd1) begin
                        // another left shift would hit the zero/subnormal exponent
                        r_y     <= {r_sign, 7'h00};
                        r_vld   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - 6'sd1;
                    end
                end
                S_DONE: begin
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_adder_e4m3.sv
// Self-checking bench for float_adder_e4m3: directed vector table, random ops
// against an integer reference model, back-to-back handshake and mid-op reset.
module tb_float_adder_e4m3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] y;
    logic       is_output_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;

    float_adder_e4m3 dut (
        .clock(clock), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .is_output_valid(is_output_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vy;
        int         vlat;
    } vec_t;

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    // Works on the numeric rules directly: integer mantissas, shift, add, renormalise.
    function automatic void ref_add(input logic [7:0] ra, input logic [7:0] rb,
                                    output logic [7:0] ry, output int rlat);
        logic [7:0] l, s;
        int el, es, ml, ms, d, dal, sum, e, sh;
        rlat = 1;
        ry   = 8'h00;
        if (ra[6:0] == 7'h7F || rb[6:0] == 7'h7F) ry = 8'h7F;
        else if (ra[6:3] == 4'd0 && rb[6:3] == 4'd0) ry = 8'h00;
        else if (ra[6:3] == 4'd0) ry = rb;
        else if (rb[6:3] == 4'd0) ry = ra;
        else begin
            if (ra[6:0] >= rb[6:0]) begin l = ra; s = rb; end
            else begin l = rb; s = ra; end
            el  = int'(l[6:3]);
            es  = int'(s[6:3]);
            ml  = 8 + int'(l[2:0]);
            ms  = 8 + int'(s[2:0]);
            d   = el - es;
            ms  = (d >= 4) ? 0 : (ms >> d);
            dal = (d > 0 && d < 4) ? d : 0;
            sum = (l[7] == s[7]) ? ml + ms : ml - ms;
            if (sum == 0) begin
                ry   = 8'h00;
                rlat = dal + 2;
            end else begin
                e  = el;
                sh = 0;
                if (sum >= 16) begin sum = sum / 2; e = e + 1; end
                while (sum < 8 && e > 1) begin sum = sum * 2; e = e - 1; sh++; end
                rlat = dal + 3 + sh;
                if (sum < 8) ry = {l[7], 7'h00};
                else if (e > 15 || (e == 15 && sum % 8 == 7)) ry = {l[7], 7'h7E};
                else ry = {l[7], 4'(e), 3'(sum % 8)};
            end
        end
    endfunction

    // Called #1 after a clock edge; returns result and accept-to-pulse latency (0 = timeout).
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         output logic [7:0] gy, output int glat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clock); #1; n++; end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL ready_wait: in_ready stuck low");
        end
        a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        glat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (is_output_valid) begin glat = k; break; end
            @(posedge clock); #1;
        end
        gy = y;
    endtask

    initial begin
        vec_t       vt[16];
        logic [7:0] gy, ey;
        int         glat, elat, pulses;
        logic [7:0] ra, rb;

        vt[0]  = '{8'h38, 8'h38, 8'h40, 3};
        vt[1]  = '{8'h3C, 8'hB8, 8'h30, 4};
        vt[2]  = '{8'h38, 8'hB8, 8'h00, 2};
        vt[3]  = '{8'h38, 8'h20, 8'h39, 6};
        vt[4]  = '{8'h38, 8'h10, 8'h38, 3};
        vt[5]  = '{8'h7E, 8'h7E, 8'h7E, 3};
        vt[6]  = '{8'hFE, 8'hFE, 8'hFE, 3};
        vt[7]  = '{8'h7F, 8'h38, 8'h7F, 1};
        vt[8]  = '{8'h00, 8'hC4, 8'hC4, 1};
        vt[9]  = '{8'h8C, 8'h08, 8'h80, 3};
        vt[10] = '{8'h80, 8'h00, 8'h00, 1};
        vt[11] = '{8'h38, 8'hFF, 8'h7F, 1};
        vt[12] = '{8'h40, 8'hB8, 8'h38, 5};
        vt[13] = '{8'h38, 8'h3F, 8'h43, 3};
        vt[14] = '{8'h77, 8'h77, 8'h7E, 3};
        vt[15] = '{8'h70, 8'h70, 8'h78, 3};

        // reset state, observed while reset is still held
        repeat (3) @(posedge clock);
        #1;
        chk8("rst_y", y, 8'h00);
        chki("rst_vld", int'(is_output_valid), 0);
        chki("rst_ready", int'(in_ready), 1);
        chki("rst_busy", int'(busy), 0);
        reset = 1'b0;

        foreach (vt[i]) begin
            do_op(vt[i].va, vt[i].vb, gy, glat);
            chk8($sformatf("vec%0d_y", i), gy, vt[i].vy);
            chki($sformatf("vec%0d_lat", i), glat, vt[i].vlat);
        end

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = {rb[7], ra[6:3] - 4'($urandom_range(0, 4)), rb[2:0]};
            ref_add(ra, rb, ey, elat);
            do_op(ra, rb, gy, glat);
            chk8($sformatf("rnd_%02h_%02h_y", ra, rb), gy, ey);
            chki($sformatf("rnd_%02h_%02h_lat", ra, rb), glat, elat);
        end

        // in_valid held high across an op, new pair accepted on the first IDLE cycle
        @(posedge clock); #1;
        a = 8'h38; b = 8'h20; in_valid = 1'b1;
        @(posedge clock); #1;
        chki("hold_busy", int'(busy), 1);
        glat = 0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            if (is_output_valid) begin glat = k; pulses++; break; end
            @(posedge clock); #1;
        end
        chki("hold_lat", glat, 6);
        chk8("hold_y", y, 8'h39);
        a = 8'h00; b = 8'hC4;
        @(posedge clock); #1;
        chki("b2b_idle_ready", int'(in_ready), 1);
        chki("b2b_idle_vld", int'(is_output_valid), 0);
        @(posedge clock); #1;
        chki("b2b_vld", int'(is_output_valid), 1);
        chk8("b2b_y", y, 8'hC4);
        in_valid = 1'b0;
        @(posedge clock); #1;
        chki("b2b_pulse_len", int'(is_output_valid), 0);

        // reset during ALIGN aborts without a pulse
        @(posedge clock); #1;
        a = 8'h38; b = 8'h20; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk8("midrst_y", y, 8'h00);
        chki("midrst_vld", int'(is_output_valid), 0);
        chki("midrst_ready", int'(in_ready), 1);
        pulses = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (is_output_valid) pulses++;
        end
        chki("midrst_no_pulse", pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_adder_e4m3.md
Name: float_adder_e4m3

Overview:
- Multi-cycle E4M3 (1 sign, 4 exponent bits with bias 7, 3 mantissa bits plus a hidden 1) adder.
- Sits directly downstream of the E4M3 multiplier and consumes its products, forming the accumulate half of an E4M3 MAC.
- Alignment and normalisation are done iteratively, one shift per cycle, under an FSM with a ready/valid input handshake.
- Rounding is truncation (round toward zero), consistent with the multiplier.

Parameters:
- BIAS, 7, exponent bias.
- MAX_FINITE, 7'h7E, magnitude used on overflow saturation (448.0).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a  input  8  operand A, E4M3
- b  input  8  operand B, E4M3
- in_valid  input  1  operands present
- in_ready  output  1  high only in IDLE; a transfer occurs on a clock edge with in_valid && in_ready
- y  output  8  result, E4M3; holds until the next DONE
- is_output_valid  output  1  one-cycle pulse while in DONE
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, sampled at clock edge):
  - state=IDLE, y=8'h00, is_output_valid=0, busy=0, all internal registers cleared.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts that operation; no output pulse is produced for it.
- Input classification:
  - exp==0 means zero (subnormals are flushed to zero, either sign).
  - S.1111.111 (0x7F/0xFF) means NaN.
- States: IDLE, ALIGN, ADD, NORM, DONE. Each state lasts 1 cycle per visit.
- IDLE, on transfer:
  - Either operand NaN -> result 8'h7F; go to DONE.
  - Both operands zero -> result 8'h00; go to DONE.
  - Exactly one operand zero -> result is the other operand; go to DONE.
  - Otherwise:
    - L = operand with the larger a[6:0]/b[6:0]; tie picks a.
    - mL and mS are the 4-bit mantissas with the hidden 1.
    - d = eL - eS.
    - If d>=4: mS=0, go to ADD. If d==0: go to ADD. Otherwise go to ALIGN.
- ALIGN: mS >>= 1 and d -= 1 each cycle; when d reaches 0, go to ADD. Shifted-out bits are discarded.
- ADD:
  - sum is 5 bits. Same sign: sum = mL + mS. Different sign: sum = mL - mS (never negative).
  - Result sign = sign of L; result exponent = eL.
  - sum==0 -> result 8'h00 (positive zero); go to DONE. Otherwise go to NORM.
- NORM, evaluated each cycle:
  - sum[4]=1 -> sum >>= 1, exp += 1, go to DONE.
  - Else sum[3]=1 -> go to DONE.
  - Else sum <<= 1, exp -= 1, stay in NORM.
  - If exp would drop to 0 -> result {sign,7'h00}; go to DONE.
- Packing (on entry to DONE):
  - exp > 15, or exp==15 with mantissa 3'b111 -> saturate to {sign, MAX_FINITE}.
  - Otherwise y = {sign, exp[3:0], sum[2:0]}.
- DONE: y is updated, is_output_valid=1 for this cycle only, next state IDLE.
- Latency, counted as cycles from the accepting edge to the is_output_valid cycle:
  - Special cases: 1.
  - Normal path: d_align + 1 (ADD) + (1 + left_shifts) (NORM) + 1 (DONE).
  - d_align is d when 0<d<4, otherwise 0.
- Back-to-back: a new transfer is possible in the cycle immediately after DONE. in_valid during busy is ignored and not queued.
- Internal exponent arithmetic is 6-bit signed, so overflow and underflow can be detected before packing.

Test Plan:
- Reset is asserted mid-ALIGN while computing 0x38+0x20 -> next cycle y=0x00, is_output_valid=0, in_ready=1, and no pulse follows.
- a=0x38 (1.0), b=0x38 -> y=0x40 (2.0), pulse 3 cycles after accept (ADD, NORM, DONE).
- a=0x3C (1.5), b=0xB8 (-1.0) -> y=0x30 (0.5), latency 4 (one left shift); a=0x38, b=0xB8 -> y=0x00, latency 2.
- a=0x38, b=0x20 (0.125) -> d=3, y=0x39 (1.125), latency 6; a=0x38, b=0x10 (d=5) -> y=0x38, latency 3.
- a=0x7E, b=0x7E -> y=0x7E (saturated); a=0xFE, b=0xFE -> y=0xFE; a=0x7F, b=0x38 -> y=0x7F with latency 1.
- a=0x00, b=0xC4 -> y=0xC4, latency 1; in_valid is held high through the whole operation -> exactly one transfer per IDLE visit, and a second operand pair is accepted the cycle after DONE.
